// File: rtl/dmem_ctrl.sv
// Data-memory controller: one word request per cycle from the access stage to a single-port sync SRAM,
// with WAIT_CYCLES stall support. Define DMEM_BOUNDS_CHECK_EN to enable out-of-range detection and err pulses.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module dmem_ctrl #(
    parameter int                     ADDR_W      = 12,
    parameter logic [`CPU_WIDTH-1:0]  BASE_ADDR   = 32'h0,
    parameter int                     WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   data_mem_req_i,
    input  logic                   data_mem_wr_en_i,
    input  logic [`CPU_WIDTH-1:0]  data_mem_addr_i,
    input  logic [`CPU_WIDTH-1:0]  data_mem_data_i,
    output logic [`CPU_WIDTH-1:0]  data_mem_data_o,
    output logic                   data_mem_ready_o,
    output logic                   data_mem_err_o,
    output logic                   sram_ce_o,
    output logic                   sram_we_o,
    output logic [ADDR_W-1:0]      sram_addr_o,
    output logic [`CPU_WIDTH-1:0]  sram_wdata_o,
    input  logic [`CPU_WIDTH-1:0]  sram_rdata_i
);

    // state | meaning
    // IDLE  | ready for a request; a zero-wait access completes here
    // BUSY  | holding the SRAM strobe through the remaining wait states
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [`CPU_WIDTH-1:0]   wdata_q;
    logic                    wr_q;
    logic [`CPU_WIDTH-1:0]   hold_q;
    logic                    rd_done_q, rd_done_d;
    logic                    oor_rd_q;

    logic [`CPU_WIDTH-1:0]   offset;
    logic [ADDR_W-1:0]       word_idx;
    logic                    out_of_range;
    logic                    accept;
    logic                    acc_ok;
    logic                    unused_bits;

    assign offset      = data_mem_addr_i - BASE_ADDR;
    assign word_idx    = offset[ADDR_W+1:2];
    assign unused_bits = ^{offset[1:0], offset[`CPU_WIDTH-1:ADDR_W+2]};

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [`CPU_WIDTH:0] SPAN = ({{`CPU_WIDTH{1'b0}}, 1'b1}) << (ADDR_W + 2);
    logic err_q;

    assign out_of_range = (data_mem_addr_i < BASE_ADDR) | ({1'b0, offset} >= SPAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & out_of_range;
        end
    end

    assign data_mem_err_o = err_q;
`else
    assign out_of_range   = 1'b0;
    assign data_mem_err_o = 1'b0;
`endif

    assign accept = data_mem_req_i & (state_q == IDLE);
    assign acc_ok = accept & ~out_of_range;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rd_done_d        = 1'b0;
        data_mem_ready_o = 1'b0;
        sram_ce_o        = 1'b0;
        sram_we_o        = 1'b0;
        sram_addr_o      = addr_q;
        sram_wdata_o     = wdata_q;
        case (state_q)
            IDLE: begin
                data_mem_ready_o = 1'b1;
                // First strobe cycle is driven straight from the request, before it is registered.
                if (acc_ok) begin
                    sram_ce_o    = 1'b1;
                    sram_we_o    = data_mem_wr_en_i;
                    sram_addr_o  = word_idx;
                    sram_wdata_o = data_mem_data_i;
                    if (WAIT_CYCLES == 0) begin
                        rd_done_d = ~data_mem_wr_en_i;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                sram_ce_o = 1'b1;
                sram_we_o = wr_q;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = IDLE;
                    rd_done_d = ~wr_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            hold_q    <= '0;
            rd_done_q <= 1'b0;
            oor_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_done_q <= rd_done_d;
            oor_rd_q  <= accept & out_of_range & ~data_mem_wr_en_i;
            if (acc_ok) begin
                addr_q  <= word_idx;
                wdata_q <= data_mem_data_i;
                wr_q    <= data_mem_wr_en_i;
            end
            if (rd_done_q) begin
                hold_q <= sram_rdata_i;
            end else if (oor_rd_q) begin
                hold_q <= '0;
            end
        end
    end

    // Completion cycle forwards the SRAM output; the hold register covers every other cycle.
    assign data_mem_data_o = rd_done_q ? sram_rdata_i :
                             oor_rd_q  ? '0 : hold_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl: three instances (W=0/AW=12, W=2/AW=4, W=3/AW=4) each with an SRAM model.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module tb_dmem_ctrl;
    localparam int WA = 0;
    localparam int WB = 2;
    localparam int WC = 3;

    logic clk;
    logic rst_n;

    logic        a_req, a_wr, a_ready, a_err, a_ce, a_we;
    logic [31:0] a_addr, a_wdata, a_data, a_swdata, a_srdata;
    logic [11:0] a_saddr;
    logic        b_req, b_wr, b_ready, b_err, b_ce, b_we;
    logic [31:0] b_addr, b_wdata, b_data, b_swdata, b_srdata;
    logic [3:0]  b_saddr;
    logic        c_req, c_wr, c_ready, c_err, c_ce, c_we;
    logic [31:0] c_addr, c_wdata, c_data, c_swdata, c_srdata;
    logic [3:0]  c_saddr;

    logic [31:0] a_mem [4096];
    logic [31:0] b_mem [16];
    logic [31:0] c_mem [16];
    int a_run, b_run, c_run;
    int a_nwr, b_nwr, c_nwr;

    logic [31:0] exp_q [$];
    int n_total;
    int n_pass;
    int saved_nwr;

    dmem_ctrl #(.ADDR_W(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(WA)) u_a (
        .clk(clk), .rst_n(rst_n),
        .data_mem_req_i(a_req), .data_mem_wr_en_i(a_wr), .data_mem_addr_i(a_addr),
        .data_mem_data_i(a_wdata), .data_mem_data_o(a_data), .data_mem_ready_o(a_ready),
        .data_mem_err_o(a_err), .sram_ce_o(a_ce), .sram_we_o(a_we), .sram_addr_o(a_saddr),
        .sram_wdata_o(a_swdata), .sram_rdata_i(a_srdata)
    );
    dmem_ctrl #(.ADDR_W(4), .BASE_ADDR(32'h0), .WAIT_CYCLES(WB)) u_b (
        .clk(clk), .rst_n(rst_n),
        .data_mem_req_i(b_req), .data_mem_wr_en_i(b_wr), .data_mem_addr_i(b_addr),
        .data_mem_data_i(b_wdata), .data_mem_data_o(b_data), .data_mem_ready_o(b_ready),
        .data_mem_err_o(b_err), .sram_ce_o(b_ce), .sram_we_o(b_we), .sram_addr_o(b_saddr),
        .sram_wdata_o(b_swdata), .sram_rdata_i(b_srdata)
    );
    dmem_ctrl #(.ADDR_W(4), .BASE_ADDR(32'h0), .WAIT_CYCLES(WC)) u_c (
        .clk(clk), .rst_n(rst_n),
        .data_mem_req_i(c_req), .data_mem_wr_en_i(c_wr), .data_mem_addr_i(c_addr),
        .data_mem_data_i(c_wdata), .data_mem_data_o(c_data), .data_mem_ready_o(c_ready),
        .data_mem_err_o(c_err), .sram_ce_o(c_ce), .sram_we_o(c_we), .sram_addr_o(c_saddr),
        .sram_wdata_o(c_swdata), .sram_rdata_i(c_srdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: an access commits (write, or read capture) on its (W+1)-th consecutive ce cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) a_run <= 0;
        else if (a_ce) begin
            if (a_run == WA) begin
                if (a_we) begin a_mem[a_saddr] <= a_swdata; a_nwr <= a_nwr + 1; end
                a_srdata <= a_mem[a_saddr];
                a_run <= 0;
            end else a_run <= a_run + 1;
        end else a_run <= 0;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_run <= 0;
        else if (b_ce) begin
            if (b_run == WB) begin
                if (b_we) begin b_mem[b_saddr] <= b_swdata; b_nwr <= b_nwr + 1; end
                b_srdata <= b_mem[b_saddr];
                b_run <= 0;
            end else b_run <= b_run + 1;
        end else b_run <= 0;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_run <= 0;
        else if (c_ce) begin
            if (c_run == WC) begin
                if (c_we) begin c_mem[c_saddr] <= c_swdata; c_nwr <= c_nwr + 1; end
                c_srdata <= c_mem[c_saddr];
                c_run <= 0;
            end else c_run <= c_run + 1;
        end else c_run <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        a_nwr = 0; b_nwr = 0; c_nwr = 0;
        a_srdata = '0; b_srdata = '0; c_srdata = '0;
        rst_n = 1'b0;
        {a_req, a_wr, b_req, b_wr, c_req, c_wr} = '0;
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0; c_addr = '0; c_wdata = '0;
        idle(3);
        rst_n = 1'b1;
        sample();
        chk("rst_ready", {31'd0, a_ready}, 32'd1);
        chk("rst_data", a_data, 32'd0);
        chk("rst_ce_we", {30'd0, a_ce, a_we}, 32'd0);
        chk("rst_saddr", {20'd0, a_saddr}, 32'd0);
        chk("rst_swdata", a_swdata, 32'd0);
        chk("rst_err", {31'd0, a_err}, 32'd0);

        // W=0: write then read back-to-back
        next_cycle();
        a_req = 1; a_wr = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
        sample();
        chk("a_wr_ce_we", {30'd0, a_ce, a_we}, 32'd3);
        chk("a_wr_saddr", {20'd0, a_saddr}, 32'd4);
        chk("a_wr_swdata", a_swdata, 32'hDEADBEEF);
        chk("a_wr_ready", {31'd0, a_ready}, 32'd1);
        next_cycle();
        a_wr = 0;
        exp_q.push_back(32'hDEADBEEF);
        sample();
        chk("a_rd_ce_we", {30'd0, a_ce, a_we}, 32'd2);
        chk("a_rd_saddr", {20'd0, a_saddr}, 32'd4);
        chk("a_rd_ready", {31'd0, a_ready}, 32'd1);
        next_cycle();
        a_req = 0;
        sample();
        chk_pop("a_rd_data", a_data);
        chk("a_mem4", a_mem[4], 32'hDEADBEEF);
        next_cycle();
        sample();
        chk("a_hold", a_data, 32'hDEADBEEF);

        // W=0: read then write to the same word returns pre-write data
        next_cycle();
        a_req = 1; a_wr = 1; a_addr = 32'h20; a_wdata = 32'h11223344;
        next_cycle();
        a_wr = 0;
        exp_q.push_back(32'h11223344);
        next_cycle();
        a_wr = 1; a_wdata = 32'h55667788;
        sample();
        chk_pop("a_raw_old", a_data);
        next_cycle();
        a_wr = 0;
        exp_q.push_back(32'h55667788);
        next_cycle();
        a_req = 0;
        sample();
        chk_pop("a_raw_new", a_data);
        idle(2);
        sample();
        chk("a_raw_hold", a_data, 32'h55667788);

        // W=2 timing with a held request
        next_cycle();
        b_req = 1; b_wr = 1; b_addr = 32'h14; b_wdata = 32'hCAFE0001;
        next_cycle();
        b_req = 0;
        idle(2);
        sample();
        chk("b_mem5", b_mem[5], 32'hCAFE0001);
        next_cycle();
        b_req = 1; b_wr = 1; b_addr = 32'h18; b_wdata = 32'h0BADF00D;
        next_cycle();
        b_req = 0;
        idle(2);
        b_req = 1; b_wr = 0; b_addr = 32'h14;
        exp_q.push_back(32'hCAFE0001);
        sample();
        chk("b_n_ready_ce", {30'd0, b_ready, b_ce}, 32'd3);
        chk("b_n_saddr", {28'd0, b_saddr}, 32'd5);
        next_cycle();
        b_addr = 32'h18;
        sample();
        chk("b_n1_ready_ce", {30'd0, b_ready, b_ce}, 32'd1);
        chk("b_n1_saddr", {28'd0, b_saddr}, 32'd5);
        next_cycle();
        sample();
        chk("b_n2_ready_ce", {30'd0, b_ready, b_ce}, 32'd1);
        chk("b_n2_saddr", {28'd0, b_saddr}, 32'd5);
        next_cycle();
        exp_q.push_back(32'h0BADF00D);
        sample();
        chk("b_n3_ready_ce", {30'd0, b_ready, b_ce}, 32'd3);
        chk_pop("b_n3_data", b_data);
        chk("b_n3_saddr", {28'd0, b_saddr}, 32'd6);
        next_cycle();
        b_req = 0;
        sample();
        chk("b_n4_ready", {31'd0, b_ready}, 32'd0);
        next_cycle();
        sample();
        chk("b_n5_ready", {31'd0, b_ready}, 32'd0);
        next_cycle();
        sample();
        chk_pop("b_n6_data", b_data);
        chk("b_n6_ready_ce", {30'd0, b_ready, b_ce}, 32'd2);
        next_cycle();
        sample();
        chk("b_n7_hold", b_data, 32'h0BADF00D);

        // W=3: load hold register, then reset in the middle of a write
        next_cycle();
        c_req = 1; c_wr = 1; c_addr = 32'h04; c_wdata = 32'hAAAA5555;
        next_cycle();
        c_req = 0;
        idle(3);
        c_req = 1; c_wr = 0;
        exp_q.push_back(32'hAAAA5555);
        next_cycle();
        c_req = 0;
        idle(3);
        sample();
        chk_pop("c_rd_data", c_data);
        next_cycle();
        saved_nwr = c_nwr;
        c_req = 1; c_wr = 1; c_addr = 32'h08; c_wdata = 32'h12345678;
        sample();
        chk("c_acc_ce_we", {30'd0, c_ce, c_we}, 32'd3);
        next_cycle();
        c_req = 0;
        sample();
        chk("c_busy_ce_we_rdy", {29'd0, c_ce, c_we, c_ready}, 32'd6);
        #1 rst_n = 1'b0;
        #1;
        chk("c_rst_ce_we", {30'd0, c_ce, c_we}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(5);
        sample();
        chk("c_post_ready", {31'd0, c_ready}, 32'd1);
        chk("c_post_data", c_data, 32'd0);
        chk("c_post_nwr", c_nwr, saved_nwr);

        // Bring the hold register back to a nonzero value
        next_cycle();
        c_req = 1; c_wr = 0; c_addr = 32'h04;
        exp_q.push_back(32'hAAAA5555);
        next_cycle();
        c_req = 0;
        idle(3);
        sample();
        chk_pop("c_rd2_data", c_data);

`ifdef DMEM_BOUNDS_CHECK_EN
        next_cycle();
        saved_nwr = c_nwr;
        c_req = 1; c_wr = 1; c_addr = 32'h40; c_wdata = 32'hA5A5A5A5;
        sample();
        chk("oob_wr_ce", {31'd0, c_ce}, 32'd0);
        chk("oob_wr_err0", {31'd0, c_err}, 32'd0);
        next_cycle();
        c_req = 0;
        sample();
        chk("oob_wr_err1", {31'd0, c_err}, 32'd1);
        chk("oob_wr_ready", {31'd0, c_ready}, 32'd1);
        next_cycle();
        sample();
        chk("oob_wr_err2", {31'd0, c_err}, 32'd0);
        chk("oob_wr_nwr", c_nwr, saved_nwr);
        chk("oob_wr_hold", c_data, 32'hAAAA5555);
        next_cycle();
        c_req = 1; c_wr = 0; c_addr = 32'h44;
        sample();
        chk("oob_rd_ce", {31'd0, c_ce}, 32'd0);
        next_cycle();
        c_req = 0;
        sample();
        chk("oob_rd_data", c_data, 32'd0);
        chk("oob_rd_err", {31'd0, c_err}, 32'd1);
        next_cycle();
        sample();
        chk("oob_rd_hold", c_data, 32'd0);
        chk("oob_rd_err2", {31'd0, c_err}, 32'd0);
`else
        next_cycle();
        c_req = 1; c_wr = 1; c_addr = 32'h40; c_wdata = 32'hA5A5A5A5;
        sample();
        chk("wrap_saddr", {28'd0, c_saddr}, 32'd0);
        chk("wrap_ce", {31'd0, c_ce}, 32'd1);
        chk("wrap_err0", {31'd0, c_err}, 32'd0);
        next_cycle();
        c_req = 0;
        sample();
        chk("wrap_err1", {31'd0, c_err}, 32'd0);
        idle(3);
        c_req = 1; c_wr = 0; c_addr = 32'h00;
        exp_q.push_back(32'hA5A5A5A5);
        next_cycle();
        c_req = 0;
        idle(3);
        sample();
        chk_pop("wrap_rd_data", c_data);
        chk("wrap_rd_err", {31'd0, c_err}, 32'd0);
`endif

        next_cycle();
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
